// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Bundle for the instruction-fetch stage. It carries the hazard
//                controls, the instruction-memory port and the IF/ID outputs.
//                The slave modport is the fetch stage. The master modport is
//                the surrounding pipeline (hazard unit, imem, decode).
//  Config      : IF_PERF_CNT_EN adds stall_cnt / flush_cnt.
//  Signals     : pc_stall, if_stall, flush, branch_target  -> fetch stage
//                imem_rdata                                -> fetch stage
//                imem_addr, id_pc, id_pc_plus4, id_inst,
//                id_valid [, stall_cnt, flush_cnt]         <- fetch stage
//  Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if;
  logic        pc_stall;
  logic        if_stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport slave (
    input  pc_stall, if_stall, flush, branch_target, imem_rdata,
    output imem_addr, id_pc, id_pc_plus4, id_inst, id_valid,
           stall_cnt, flush_cnt
  );
  modport master (
    output pc_stall, if_stall, flush, branch_target, imem_rdata,
    input  imem_addr, id_pc, id_pc_plus4, id_inst, id_valid,
           stall_cnt, flush_cnt
  );
`else
  modport slave (
    input  pc_stall, if_stall, flush, branch_target, imem_rdata,
    output imem_addr, id_pc, id_pc_plus4, id_inst, id_valid
  );
  modport master (
    output pc_stall, if_stall, flush, branch_target, imem_rdata,
    input  imem_addr, id_pc, id_pc_plus4, id_inst, id_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage plus the IF/ID pipeline register.
//                It holds the PC and drives the instruction-memory address.
//                It registers the fetched word for decode, and it applies the
//                stall and flush controls from the hazard unit.
//  Config      : Define IF_PERF_CNT_EN to get the saturating stall and flush
//                counters.
//  Ports       : clk        - clock. All state updates on the rising edge.
//                rst        - synchronous active-high reset.
//                bus        - if_stage_if.slave. Holds the hazard controls,
//                             the imem port and the IF/ID outputs.
//  Parameters  : RESET_PC   - PC loaded on reset.
//                NOP_INST   - bubble instruction placed in IF/ID.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.slave bus
);

  localparam logic [31:0] c_PC_STEP   = 32'd4;
  localparam logic [31:0] c_ALIGN_MSK = 32'hFFFF_FFFC;
  localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_any_stall;

  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  // The sum wraps naturally modulo 2^32.
  assign w_pc_plus4  = r_pc + c_PC_STEP;
  // Redirect targets are forced word aligned. The low bits are dropped.
  assign w_target    = bus.branch_target & c_ALIGN_MSK;
  // A stall from either source freezes the PC, so no fetch is lost.
  assign w_any_stall = bus.pc_stall | bus.if_stall;

  // Program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.flush) begin
      r_pc <= w_target;
    end else if (!w_any_stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register. When the PC is held and IF/ID is free, the register
  // takes a bubble. Loading the held fetch instead would let decode see
  // the same instruction twice.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_id_pc       <= 32'h0000_0000;
      r_id_pc_plus4 <= c_PC_STEP;
      r_id_inst     <= NOP_INST;
      r_id_valid    <= 1'b0;
    end else if (bus.if_stall) begin
      r_id_pc       <= r_id_pc;
      r_id_pc_plus4 <= r_id_pc_plus4;
      r_id_inst     <= r_id_inst;
      r_id_valid    <= r_id_valid;
    end else if (bus.pc_stall) begin
      r_id_pc       <= 32'h0000_0000;
      r_id_pc_plus4 <= c_PC_STEP;
      r_id_inst     <= NOP_INST;
      r_id_valid    <= 1'b0;
    end else begin
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_inst     <= bus.imem_rdata;
      r_id_valid    <= 1'b1;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_pc_plus4 = r_id_pc_plus4;
  assign bus.id_inst     = r_id_inst;
  assign bus.id_valid    = r_id_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // A cycle with a flush counts only as a flush. The flush overrides the
  // stall, so that cycle is not a stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'h0000_0000;
      r_flush_cnt <= 32'h0000_0000;
    end else begin
      if (w_any_stall && !bus.flush && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (bus.flush && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed bench for if_stage. A table of per-cycle vectors
//                drives the main DUT. A second DUT with RESET_PC=FFFF_FFFC
//                shows that the PC wraps. Instruction memory returns
//                addr ^ 32'hA5A5_0000.
//  Config      : The counter checks are built only when IF_PERF_CNT_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;
  localparam logic [31:0] c_KEY = 32'hA5A5_0000;
  localparam int          c_NV  = 19;

  logic clk;
  logic rst;

  if_stage_if bif ();
  if_stage_if wif ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(c_NOP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(c_NOP)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wif.slave)
  );

  assign bif.imem_rdata = bif.imem_addr ^ c_KEY;
  assign wif.imem_rdata = wif.imem_addr ^ c_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ps;
    logic        is;
    logic        fl;
    logic [31:0] bt;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs [c_NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //                rst   ps    is    fl    bt            addr          id_pc         id_inst       vld   stall  flush
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 32'h0000_0000, c_NOP,        1'b0, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'hA5A5_0000, 1'b1, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 32'd1, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 32'd2, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_000C, 32'h0000_0008, 32'hA5A5_0008, 1'b1, 32'd2, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0010, 32'h0000_000C, 32'hA5A5_000C, 1'b1, 32'd2, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, c_NOP,        1'b0, 32'd2, 32'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0104, 32'h0000_0100, 32'hA5A5_0100, 1'b1, 32'd2, 32'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, c_NOP,        1'b0, 32'd2, 32'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0044, 32'h0000_0040, 32'hA5A5_0040, 1'b1, 32'd2, 32'd2};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0044, 32'h0000_0000, c_NOP,        1'b0, 32'd3, 32'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0048, 32'h0000_0044, 32'hA5A5_0044, 1'b1, 32'd3, 32'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0048, 32'h0000_0044, 32'hA5A5_0044, 1'b1, 32'd4, 32'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_004C, 32'h0000_0048, 32'hA5A5_0048, 1'b1, 32'd4, 32'd2};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_004C, 32'h0000_0048, 32'hA5A5_0048, 1'b1, 32'd5, 32'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_004C, 32'h0000_0048, 32'hA5A5_0048, 1'b1, 32'd6, 32'd2};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0000, 32'h0000_0000, c_NOP,        1'b0, 32'd0, 32'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'hA5A5_0000, 1'b1, 32'd0, 32'd0};

    rst               = 1'b1;
    bif.pc_stall      = 1'b0;
    bif.if_stall      = 1'b0;
    bif.flush         = 1'b0;
    bif.branch_target = 32'h0;
    wif.pc_stall      = 1'b0;
    wif.if_stall      = 1'b0;
    wif.flush         = 1'b0;
    wif.branch_target = 32'h0;

    for (int i = 0; i < c_NV; i++) begin
      @(negedge clk);
      rst               = vecs[i].rst;
      bif.pc_stall      = vecs[i].ps;
      bif.if_stall      = vecs[i].is;
      bif.flush         = vecs[i].fl;
      bif.branch_target = vecs[i].bt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d imem_addr", i), bif.imem_addr, vecs[i].addr);
      check($sformatf("v%0d id_pc", i), bif.id_pc, vecs[i].pc);
      check($sformatf("v%0d id_pc_plus4", i), bif.id_pc_plus4, vecs[i].pc + 32'd4);
      check($sformatf("v%0d id_inst", i), bif.id_inst, vecs[i].inst);
      check($sformatf("v%0d id_valid", i), {31'd0, bif.id_valid}, {31'd0, vecs[i].valid});
`ifdef IF_PERF_CNT_EN
      check($sformatf("v%0d stall_cnt", i), bif.stall_cnt, vecs[i].sc);
      check($sformatf("v%0d flush_cnt", i), bif.flush_cnt, vecs[i].fc);
`endif
    end

    // Wrap case: reset the second DUT to the last word, then let it run.
    @(negedge clk);
    rst          = 1'b1;
    bif.pc_stall = 1'b0;
    bif.if_stall = 1'b0;
    bif.flush    = 1'b0;
    @(posedge clk);
    #1;
    check("wrap reset imem_addr", wif.imem_addr, 32'hFFFF_FFFC);
    check("wrap reset id_valid", {31'd0, wif.id_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("wrap imem_addr", wif.imem_addr, 32'h0000_0000);
    check("wrap id_pc", wif.id_pc, 32'hFFFF_FFFC);
    check("wrap id_pc_plus4", wif.id_pc_plus4, 32'h0000_0000);
    check("wrap id_inst", wif.id_inst, 32'h5A5A_FFFC);
    @(posedge clk);
    #1;
    check("wrap next imem_addr", wif.imem_addr, 32'h0000_0004);
    check("wrap next id_pc", wif.id_pc, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage RISC-V core. Holds the program counter, drives the instruction-memory address, and registers the fetched instruction for decode. Consumes the PC-stall, IF/ID-stall and flush controls produced by the hazard detection unit, plus the branch target, so that load-use stalls and taken branches take effect at the front of the pipeline.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID on reset and flush

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_stall  in  1  hold PC (hazard unit PC-stall)
- if_stall  in  1  hold IF/ID register (hazard unit IF-stall)
- flush  in  1  redirect to branch_target and squash IF/ID
- branch_target  in  32  redirect address, sampled when flush=1
- imem_addr  out  32  instruction-memory address, equal to current PC
- imem_rdata  in  32  instruction word, combinational from imem_addr
- id_pc  out  32  PC of instruction in IF/ID
- id_pc_plus4  out  32  id_pc + 4
- id_inst  out  32  instruction in IF/ID
- id_valid  out  1  1 = id_inst is a real fetched instruction, 0 = bubble
- stall_cnt  out  32  stall-cycle counter (only with IF_PERF_CNT_EN)
- flush_cnt  out  32  flush counter (only with IF_PERF_CNT_EN)

## Operation
- PC next-value priority (evaluated every edge): rst -> RESET_PC; flush -> {branch_target[31:2],2'b00}; pc_stall|if_stall -> hold; else PC+4.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no exception raised.
- branch_target[1:0] ignored; PC[1:0] always 00.
- IF/ID next-value priority: rst -> {pc=0, pc_plus4=4, inst=NOP_INST, valid=0}; flush -> same bubble values; if_stall -> hold all fields; pc_stall (with if_stall=0) -> bubble (prevents duplicating the held instruction); else {pc=PC, pc_plus4=PC+4, inst=imem_rdata, valid=1}.
- if_stall alone also holds the PC (an instruction is never dropped).
- flush overrides both stalls when asserted together; the redirect is never lost.
- id_pc_plus4 is stored, not recomputed, and always equals id_pc+4 mod 2^32.

## Timing
- imem_addr is a register output; reads combinationally in the same cycle.
- Fetch-to-decode latency: 1 cycle (instruction at PC X visible on id_inst the cycle after imem_addr=X, absent stalls).
- Redirect: flush in cycle N -> imem_addr=target in N+1, id_valid=0 in N+1, target instruction on id_inst in N+2.
- Stall: pc_stall=if_stall=1 for K cycles -> imem_addr and id_* frozen for K cycles, fetch resumes on the edge after deassertion.
- Reset outputs: imem_addr=RESET_PC, id_pc=0, id_pc_plus4=4, id_inst=NOP_INST, id_valid=0, counters 0. First valid fetch appears on id_inst one cycle after rst drops.
- rst asserted mid-stall or mid-flush wins unconditionally in that cycle.

## Configuration
- IF_PERF_CNT_EN defined: stall_cnt increments on every non-reset edge with (pc_stall|if_stall)&!flush; flush_cnt increments on every non-reset edge with flush=1; both saturate at 32'hFFFF_FFFF; both clear on rst.
- IF_PERF_CNT_EN undefined: stall_cnt, flush_cnt ports and logic are absent; all other behaviour identical.

## Test plan
- Reset then free-run, imem returns addr^32'hA5A5_0000 -> id_inst sequence for PCs 0,4,8,12 with id_valid=1 from 2nd cycle after rst low; id_pc_plus4=id_pc+4.
- Load-use: pc_stall=if_stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, id_pc stays 4, then resumes 12; stall_cnt=2.
- Branch: flush=1, branch_target=32'h0000_0103 at PC=16 -> next imem_addr=32'h100, id_valid=0, id_inst=NOP_INST, then id_pc=32'h100; flush_cnt=1.
- Simultaneous flush+pc_stall+if_stall, target 32'h40 -> redirect taken, imem_addr=32'h40, bubble in IF/ID, stall_cnt unchanged.
- pc_stall=1, if_stall=0 one cycle -> PC held, id_valid=0 next cycle, no duplicated instruction; RESET_PC=32'hFFFF_FFFC -> imem_addr wraps to 0 next cycle.
- rst asserted during a 3-cycle stall -> imem_addr=RESET_PC, id_valid=0, counters 0 on the following cycle.
